serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Parametrised multi-cycle add/subtract unit for the calculator datapath; generalises the 4-bit subtractor.
//  Processes operands CHUNK bits per cycle, LSB chunk first, with a start/busy/done handshake.
//  Produces a result plus carry/borrow, overflow, negative and zero flags, with optional saturation.
//  Sits between the operand registers and the display/result register in the calculator top level.
// PARAMETERS
//  WIDTH    8  operand/result width in bits; must be a multiple of CHUNK.
//  CHUNK    4  bits processed per cycle; N = WIDTH/CHUNK cycles per operation.
//  SATURATE 0  0 = wrap-around result; 1 = clamp to range limits on overflow/borrow.
// PORTS
//  clk           in   1      rising-edge clock.
//  rst_n         in   1      asynchronous, active-low reset.
//  start         in   1      request; sampled only in IDLE or DONE.
//  op            in   1      0 = a+b, 1 = a-b; sampled with start.
//  is_signed     in   1      1 = two's-complement operands; sampled with start.
//  a             in   WIDTH  first operand; sampled with start.
//  b             in   WIDTH  second operand; sampled with start.
//  busy          out  1      high while the operation is in progress.
//  done          out  1      one-cycle pulse; result and flags are valid from this cycle.
//  result        out  WIDTH  final result; held until the next completion.
//  carry_borrow  out  1      add: carry out; sub: borrow (unsigned a<b).
//  overflow      out  1      signed overflow of the unclamped result; 0 when is_signed=0.
//  negative      out  1      result[WIDTH-1] when is_signed=1, else 0.
//  zero          out  1      result == 0 (after saturation).
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, result, carry_borrow, overflow, negative, zero all 0.
//  FSM states: IDLE -> BUSY on start; BUSY -> DONE after N chunk cycles; DONE -> IDLE, or DONE -> BUSY on start.
//  Capture: on the edge that accepts start, latch a, b, op and is_signed; set the chunk counter to 0.
//   The carry register is loaded with op, so that sub = a + ~b + 1.
//  BUSY: on each edge, sum chunk k = a_k + (op ? ~b_k : b_k) + carry; write it into the partial-result register; update carry.
//  Latency: start accepted at edge 0; busy=1 for cycles 0..N-1.
//   At edge N, result and flags update, done=1 for exactly one cycle and busy=0.
//  start while BUSY is ignored; operand changes while BUSY have no effect.
//  Back-to-back: start high during the DONE cycle is accepted; busy reasserts on the next cycle.
//  Flags are computed on the full WIDTH-bit raw sum.
//   co is the carry out of the MSB chunk.
//   carry_borrow = op ? ~co : co.
//   overflow = is_signed & (sa==sb') & (sr!=sa), where sb' = MSB of b after optional inversion.
//  Saturation (SATURATE=1):
//   Unsigned add with carry -> all ones.
//   Unsigned sub with borrow -> 0.
//   Signed overflow -> 0111..1 if sa=0, 1000..0 if sa=1.
//   Flags still report the overflow/borrow condition.
//  SATURATE=0: result is the raw sum mod 2^WIDTH.
//  negative and zero always reflect the final, possibly clamped, result.
//  Reset mid-BUSY: the operation is aborted; done never pulses; outputs return to reset values.
//  Outputs keep their last completed values through IDLE and the next BUSY until the next done.
// TESTING (WIDTH=8, CHUNK=4, N=2 unless stated)
//  Unsigned sub 0x05-0x03 -> done 2 cycles after start, result=0x02, carry_borrow=0, zero=0.
//  Unsigned sub 0x03-0x05 -> SATURATE=0: 0xFE, carry_borrow=1. SATURATE=1: 0x00, carry_borrow=1, zero=1.
//  Signed add 0x7F+0x01 -> SATURATE=0: 0x80, overflow=1, negative=1. SATURATE=1: 0x7F, overflow=1.
//  Unsigned add 0xFF+0x01 -> result=0x00, carry_borrow=1, zero=1.
//   A second start pulse during BUSY is ignored (one done only).
//   start held high in the DONE cycle starts the next operation immediately.
//  rst_n low in the first BUSY cycle -> busy=0 and result=0 immediately; no done pulse; next start behaves normally.
//  WIDTH=16, CHUNK=1: 0x8000-0x0001 signed -> done after 16 cycles, result=0x7FFF, overflow=1.

Source files
------------

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - multi-cycle chunked add/subtract unit with flags and optional saturation
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start               request, accepted in IDLE or DONE
//   op                  0 = a+b, 1 = a-b (captured with start)
//   is_signed           two's-complement interpretation (captured with start)
//   a, b                operands (captured with start)
//   busy                high while chunks are being processed
//   done                one-cycle completion pulse
//   result              final (possibly clamped) result, held until the next done
//   carry_borrow        add: carry out, sub: unsigned borrow
//   overflow            signed overflow of the unclamped sum
//   negative, zero      sign and zero status of the final result
module serial_addsub #(
    parameter int WIDTH    = 8,
    parameter int CHUNK    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q, partial;
    logic             op_q, sgn_q, carry;
    logic [CW-1:0]    cnt;

    logic             accept, last;
    logic [CHUNK-1:0] a_k, bx_k;
    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] raw, final_res;
    logic             co, sa, sbx, sr, ovf, cb;

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign last   = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_BUSY;
            end
            S_BUSY: begin
                busy = 1'b1;
                if (last) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = start ? S_BUSY : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // One chunk per cycle; the chunk sum is merged into a copy of the partial
    // register so the last cycle sees the complete raw sum for flag evaluation.
    always_comb begin
        a_k  = a_q[cnt*CHUNK +: CHUNK];
        bx_k = op_q ? ~b_q[cnt*CHUNK +: CHUNK] : b_q[cnt*CHUNK +: CHUNK];
        csum = {1'b0, a_k} + {1'b0, bx_k} + {{CHUNK{1'b0}}, carry};
        co   = csum[CHUNK];
        raw  = partial;
        raw[cnt*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    end

    // Flags and clamping, meaningful on the last chunk cycle
    always_comb begin
        sa        = a_q[WIDTH-1];
        sbx       = b_q[WIDTH-1] ^ op_q;
        sr        = raw[WIDTH-1];
        ovf       = sgn_q & (sa == sbx) & (sr != sa);
        cb        = op_q ? ~co : co;
        final_res = raw;
        if (SATURATE != 0) begin
            if (sgn_q) begin
                if (ovf) final_res = sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else if (cb) begin
                final_res = op_q ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 1'b0;
            sgn_q        <= 1'b0;
            carry        <= 1'b0;
            cnt          <= '0;
            partial      <= '0;
            result       <= '0;
            carry_borrow <= 1'b0;
            overflow     <= 1'b0;
            negative     <= 1'b0;
            zero         <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            sgn_q   <= is_signed;
            // Carry-in of one turns a + ~b into a - b
            carry   <= op;
            cnt     <= '0;
            partial <= '0;
        end else if (state == S_BUSY) begin
            partial <= raw;
            carry   <= co;
            cnt     <= cnt + 1'b1;
            if (last) begin
                result       <= final_res;
                carry_borrow <= cb;
                overflow     <= ovf;
                negative     <= sgn_q & final_res[WIDTH-1];
                zero         <= (final_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed self-checking bench for serial_addsub
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        is_signed = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;

    logic        busy_w, done_w, cb_w, ovf_w, neg_w, zero_w;
    logic [7:0]  res_w;
    logic        busy_s, done_s, cb_s, ovf_s, neg_s, zero_s;
    logic [7:0]  res_s;

    logic        start16 = 1'b0;
    logic        op16 = 1'b0;
    logic        sgn16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16, done16, cb16, ovf16, neg16, zero16;
    logic [15:0] res16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .CHUNK(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy_w), .done(done_w), .result(res_w),
        .carry_borrow(cb_w), .overflow(ovf_w), .negative(neg_w), .zero(zero_w)
    );

    serial_addsub #(.WIDTH(8), .CHUNK(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy_s), .done(done_s), .result(res_s),
        .carry_borrow(cb_s), .overflow(ovf_s), .negative(neg_s), .zero(zero_s)
    );

    serial_addsub #(.WIDTH(16), .CHUNK(1), .SATURATE(0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .is_signed(sgn16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .result(res16),
        .carry_borrow(cb16), .overflow(ovf16), .negative(neg16), .zero(zero16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request for one cycle; returns at the negedge of busy cycle 0
    task automatic issue(input logic o, input logic s, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        op = o; is_signed = s; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_w && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int ndone;
    int nbusy;

    initial begin
        #12;
        check("rst_busy", busy_w, 0);
        check("rst_done", done_w, 0);
        check("rst_res", res_w, 0);
        check("rst_flags", {cb_w, ovf_w, neg_w, zero_w}, 0);
        check("rst16_res", res16, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0x05 - 0x03 unsigned
        issue(1'b1, 1'b0, 8'h05, 8'h03);
        check("sub1_busy0", busy_w, 1);
        wait_done(cyc);
        check("sub1_lat", cyc, 2);
        check("sub1_res", res_w, 8'h02);
        check("sub1_cb", cb_w, 0);
        check("sub1_zero", zero_w, 0);
        check("sub1_sat_res", res_s, 8'h02);
        check("sub1_busy_at_done", busy_w, 0);
        @(negedge clk);
        check("sub1_done_pulse", done_w, 0);

        // 0x03 - 0x05 unsigned: borrow
        issue(1'b1, 1'b0, 8'h03, 8'h05);
        wait_done(cyc);
        check("sub2_lat", cyc, 2);
        check("sub2_res", res_w, 8'hFE);
        check("sub2_cb", cb_w, 1);
        check("sub2_sat_res", res_s, 8'h00);
        check("sub2_sat_cb", cb_s, 1);
        check("sub2_sat_zero", zero_s, 1);

        // 0x7F + 0x01 signed: overflow
        issue(1'b0, 1'b1, 8'h7F, 8'h01);
        wait_done(cyc);
        check("add1_res", res_w, 8'h80);
        check("add1_ovf", ovf_w, 1);
        check("add1_neg", neg_w, 1);
        check("add1_sat_res", res_s, 8'h7F);
        check("add1_sat_ovf", ovf_s, 1);
        check("add1_sat_neg", neg_s, 0);

        // 0xFF + 0x01 unsigned, with a stray start during BUSY
        issue(1'b0, 1'b0, 8'hFF, 8'h01);
        start = 1'b1; a = 8'h11; b = 8'h22;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("add2_seen_done", done_w, 1);
        check("add2_res", res_w, 8'h00);
        check("add2_cb", cb_w, 1);
        check("add2_zero", zero_w, 1);
        check("add2_sat_res", res_s, 8'hFF);
        check("add2_sat_zero", zero_s, 0);
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_w) ndone++;
            if (busy_w) nbusy++;
        end
        check("add2_extra_done", ndone, 0);
        check("add2_extra_busy", nbusy, 0);
        check("add2_res_held", res_w, 8'h00);

        // Back-to-back: start held in the DONE cycle
        issue(1'b0, 1'b0, 8'h10, 8'h20);
        wait_done(cyc);
        check("b2b1_res", res_w, 8'h30);
        op = 1'b1; a = 8'h50; b = 8'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b2_busy", busy_w, 1);
        check("b2b2_done", done_w, 0);
        check("b2b2_res_held", res_w, 8'h30);
        wait_done(cyc);
        check("b2b2_lat", cyc, 2);
        check("b2b2_res", res_w, 8'h40);

        // Reset in the first BUSY cycle
        issue(1'b0, 1'b0, 8'h12, 8'h34);
        check("rstmid_busy_before", busy_w, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_busy", busy_w, 0);
        check("rstmid_res", res_w, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_w) ndone++;
        end
        check("rstmid_no_done", ndone, 0);
        issue(1'b0, 1'b0, 8'h12, 8'h34);
        wait_done(cyc);
        check("rstmid_next_lat", cyc, 2);
        check("rstmid_next_res", res_w, 8'h46);

        // 16-bit, 1-bit chunks: 0x8000 - 0x0001 signed
        @(negedge clk);
        op16 = 1'b1; sgn16 = 1'b1; a16 = 16'h8000; b16 = 16'h0001; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 0;
        while (!done16 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("w16_lat", cyc, 16);
        check("w16_res", res16, 16'h7FFF);
        check("w16_ovf", ovf16, 1);
        check("w16_cb", cb16, 0);
        check("w16_neg", neg16, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
